// File: rtl/spi_master_param.sv
// Parametrised SPI master: runtime CPOL/CPHA, clock divider and bit order,
// multiple active-low chip selects, start/busy/done handshake.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              SPI_MISO,
  output logic              SPI_MOSI,
  output logic              SPI_CLK,
  output logic [NUM_CS-1:0] SPI_EN,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);
  localparam logic [CS_W:0] NUM_CS_L = (CS_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  function automatic logic [NUM_CS-1:0] cs_decode_low(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    for (int i = 0; i < NUM_CS; i++) begin
      v[i] = (CS_W'(i) != sel);
    end
    return v;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b,
                                                 input logic lsb);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                launch;
  logic                tick;
  logic [EDGE_W-1:0]   e_new;

  // Next-state and datapath: phase sequencing plus the per-SCLK-edge shift/sample actions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    shadow_d   = shadow_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    launch     = 1'b0;
    e_new      = edge_q + FIRST_EDGE;
    tick       = (cnt_q == div_q);

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        cnt_d  = '0;
        if (SPI_start) begin
          if ({1'b0, cs_sel} < NUM_CS_L) begin
            state_d = ST_LEAD;
            tx_d    = data_in;
            div_d   = clk_div;
            cpol_d  = cpol;
            cpha_d  = cpha;
            lsb_d   = lsb_first;
            edge_d  = '0;
            busy_d  = 1'b1;
            en_d    = cs_decode_low(cs_sel);
            mosi_d  = first_bit(data_in, lsb_first);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d = ST_XFER;
          launch  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_XFER: begin
        if (tick) begin
          launch = 1'b1;
          cnt_d  = '0;
          if (e_new == LAST_EDGE) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          en_d       = '1;
          busy_d     = 1'b0;
          mosi_d     = 1'b0;
          data_out_d = shadow_q;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Odd edges are leading; the sampling edge is the leading one for cpha=0, trailing for cpha=1.
    if (launch) begin
      sclk_d = ~sclk_q;
      edge_d = e_new;
      if (e_new[0] != cpha_q) begin
        shadow_d = shift_in(shadow_q, SPI_MISO, lsb_q);
      end else if ((e_new != LAST_EDGE) && (e_new != FIRST_EDGE)) begin
        tx_d   = shift_tx(tx_q, lsb_q);
        mosi_d = first_bit(tx_d, lsb_q);
      end else begin
        tx_d = tx_q;
      end
    end else begin
      edge_d = edge_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      shadow_q   <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      en_q       <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      shadow_q   <= shadow_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
    end
  end

  assign SPI_MOSI = mosi_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_EN   = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed plus randomized bench for spi_master_param; expected waveforms come
// from per-cycle arithmetic on the frame timing (level index = cycle / H).
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic [7:0] data_in;
  logic [1:0] cs_sel, cs3;
  logic       cpol, cpha, lsb_first;
  logic [7:0] clk_div;
  logic       miso_drv, loopback;
  logic       miso;
  logic       mosi, sclk, busy, done, err;
  logic [3:0] en;
  logic [7:0] data_out;
  logic       mosi3, sclk3, busy3, done3, err3;
  logic [2:0] en3;
  logic [7:0] data_out3;

  int n_cmp = 0;
  int n_bad = 0;

  assign miso = loopback ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .SPI_start(start), .data_in(data_in), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .SPI_MISO(miso), .SPI_MOSI(mosi), .SPI_CLK(sclk), .SPI_EN(en),
    .busy(busy), .done(done), .data_out(data_out), .err(err)
  );

  // NUM_CS=3 leaves cs_sel=3 representable, so the reject path can be exercised.
  spi_master_param #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) dut3 (
    .clk(clk), .rst(rst), .SPI_start(start3), .data_in(data_in), .cs_sel(cs3),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .SPI_MISO(miso), .SPI_MOSI(mosi3), .SPI_CLK(sclk3), .SPI_EN(en3),
    .busy(busy3), .done(done3), .data_out(data_out3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame; inputs are scrambled right after accept to show they are latched.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] s, input logic [1:0] cs,
                           input logic pol, input logic pha, input logic lsb,
                           input logic [7:0] div, input logic loop, input logic poke);
    int h, total, lvl, idx, edges;
    logic prev, sclk_e, mosi_e;
    logic [8:0] ev;
    h = int'(div) + 1;
    total = 17 * h;
    @(posedge clk); #1;
    data_in = d; cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb;
    clk_div = div; loopback = loop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = ~d; cs_sel = cs ^ 2'd1; cpol = ~pol; cpha = ~pha; lsb_first = ~lsb;
    clk_div = 8'($urandom);
    edges = 0;
    prev = pol;
    for (int c = 0; c < total; c++) begin
      lvl = c / h;
      if (pha) idx = (lvl == 0) ? 0 : (lvl - 1) / 2;
      else idx = lvl / 2;
      if (idx > 7) idx = 7;
      miso_drv = lsb ? s[idx] : s[7 - idx];
      start = poke && (c == 5 * h);
      sclk_e = pol ^ lvl[0];
      mosi_e = lsb ? d[idx] : d[7 - idx];
      ev = {1'b1, ~(4'b0001 << cs), sclk_e, mosi_e, 1'b0, 1'b0};
      check($sformatf("cycle%0d", c), 32'({busy, en, sclk, mosi, done, err}), 32'(ev));
      if (sclk !== prev) edges++;
      prev = sclk;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_cycle", 32'({busy, en, sclk, mosi, done, err}),
          32'({1'b0, 4'hF, pol, 1'b0, 1'b1, 1'b0}));
    check("data_out", 32'(data_out), 32'(loop ? d : s));
    check("sclk_edges", 32'(edges), 32'd16);
    cpol = pol;
    @(posedge clk); #1;
    check("after_done", 32'({busy, done, en}), 32'({1'b0, 1'b0, 4'hF}));
  endtask

  initial begin
    int nd, t1, t2, en_high, got;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; data_in = 8'h00; cs_sel = 2'd0; cs3 = 2'd0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; miso_drv = 1'b0; loopback = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, en, sclk, mosi, done, err}), 32'({1'b0, 4'hF, 4'b0000}));
    check("reset_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Reset at SCLK edge 7 of the first frame after power-up.
    @(posedge clk); #1;
    data_in = 8'hC3; cs_sel = 2'd1; cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midframe_reset", 32'({busy, en, sclk, mosi, done, err}), 32'({1'b0, 4'hF, 4'b0000}));
    check("midframe_reset_dout", 32'(data_out), 32'd0);
    #2;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("no_done_after_reset", 32'(nd), 32'd0);
    check("idle_after_reset", 32'({busy, en, sclk}), 32'({1'b0, 4'hF, 1'b1}));

    run_frame(8'hA5, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      run_frame(8'h96, 8'h00, 2'd1, m[1], m[0], 1'b0, 8'd2, 1'b1, m == 1);
    end
    run_frame(8'h01, 8'h80, 2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);

    // Reject path on the 3-select instance, then a valid frame on it.
    @(posedge clk); #1;
    cs3 = 2'd3; start3 = 1'b1; clk_div = 8'd0; loopback = 1'b0;
    @(posedge clk); #1;
    start3 = 1'b0;
    check("err_pulse", 32'({err3, busy3, en3}), 32'({1'b1, 1'b0, 3'b111}));
    @(posedge clk); #1;
    check("err_cleared", 32'({err3, busy3, en3}), 32'({1'b0, 1'b0, 3'b111}));
    cs3 = 2'd2; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    check("cs3_select", 32'({err3, busy3, en3}), 32'({1'b0, 1'b1, 3'b011}));
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(posedge clk); #1;
      if (done3) got = 1;
    end
    check("cs3_done", 32'(got), 32'd1);

    // Back-to-back: start held through the first done cycle.
    @(posedge clk); #1;
    data_in = 8'h5A; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0;
    clk_div = 8'd0; loopback = 1'b1; start = 1'b1;
    t1 = -1; t2 = -1; en_high = 0;
    for (int cyc = 0; cyc < 80 && t2 < 0; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
      if (t1 >= 0 && t2 < 0 && en == 4'hF) en_high++;
      if (t1 >= 0 && cyc > t1) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_first_done", 32'(t1), 32'd17);
    check("b2b_spacing", 32'(t2 - t1), 32'd18);
    check("b2b_en_gap", 32'(en_high), 32'd1);
    check("b2b_data_out", 32'(data_out), 32'h5A);
    @(posedge clk); #1;
    check("b2b_idle", 32'({busy, done}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_frame(8'($urandom), 8'($urandom), 2'd3, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
